// File: rtl/kth_bit_pkg.sv
// Shared constants and helpers for the k-th bit locator pipeline.
// Helpers work on a fixed maximum width; callers zero-extend narrower vectors.
package kth_bit_pkg;
    localparam logic MODE_SET   = 1'b0;
    localparam logic MODE_CLEAR = 1'b1;
    localparam logic DIR_LSB    = 1'b0;
    localparam logic DIR_MSB    = 1'b1;

    localparam int MAX_W = 1024;
    localparam int CNT_W = 11;

    function automatic int l_of(input int w);
        return (w <= 1) ? 0 : $clog2(w);
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Reverses the low w bits of v; bits at and above w come back zero.
    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction
endpackage

// File: rtl/kth_descent_stage.sv
// One binary-descent level: split the window, steer k into the half holding the k-th bit,
// and register the narrowed window. Holds while en=0; flush drops the valid.
module kth_descent_stage
    import kth_bit_pkg::*;
#(
    parameter int WI    = 32,
    parameter int L     = 5,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic              in_vld,
    input  logic [WI-1:0]     in_win,
    input  logic [L:0]        in_k,
    input  logic [L-1:0]      in_idx,
    input  logic              in_msb,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_vld,
    output logic [WI/2-1:0]   out_win,
    output logic [L:0]        out_k,
    output logic [L-1:0]      out_idx,
    output logic              out_msb,
    output logic [TAG_W-1:0]  out_tag
);
    localparam int HW  = WI / 2;
    localparam int BIT = $clog2(WI) - 1;

    logic [L:0]       w_lo;
    logic             w_go_hi;
    logic [HW-1:0]    w_win_n;
    logic [L:0]       w_k_n;
    logic [L-1:0]     w_idx_n;
    logic [MAX_W-1:0] w_ext;
    logic [CNT_W-1:0] w_cnt;

    logic             r_vld;
    logic [HW-1:0]    r_win;
    logic [L:0]       r_k;
    logic [L-1:0]     r_idx;
    logic             r_msb;
    logic [TAG_W-1:0] r_tag;

    always_comb begin
        w_ext          = '0;
        w_ext[HW-1:0]  = in_win[HW-1:0];
        w_cnt          = popcount(w_ext);
        w_lo           = w_cnt[L:0];
        // k > lo means the target lies above the lower half; k - lo cannot underflow here
        w_go_hi        = (in_k > w_lo);
        w_k_n          = w_go_hi ? (in_k - w_lo) : in_k;
        w_win_n        = w_go_hi ? in_win[WI-1:HW] : in_win[HW-1:0];
        w_idx_n        = in_idx;
        w_idx_n[BIT]   = w_go_hi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_win <= '0;
            r_k   <= '0;
            r_idx <= '0;
            r_msb <= 1'b0;
            r_tag <= '0;
        end else begin
            if (flush)   r_vld <= 1'b0;
            else if (en) r_vld <= in_vld;
            if (en) begin
                r_win <= w_win_n;
                r_k   <= w_k_n;
                r_idx <= w_idx_n;
                r_msb <= in_msb;
                r_tag <= in_tag;
            end
        end
    end

    assign out_vld = r_vld;
    assign out_win = r_win;
    assign out_k   = r_k;
    assign out_idx = r_idx;
    assign out_msb = r_msb;
    assign out_tag = r_tag;
endmodule

// File: rtl/kth_bit_finder_pipe.sv
// Pipelined k-th set/clear bit locator, LSB- or MSB-relative, one descent level per stage.
// Latency L=$clog2(W) cycles; a stalled output freezes the whole pipe, flush drops all ops.
module kth_bit_finder_pipe
    import kth_bit_pkg::*;
#(
    parameter int W     = 32,
    parameter int TAG_W = 4,
    localparam int L    = l_of(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [L:0]       in_k,
    input  logic             in_mode_clear,
    input  logic             in_mode_msb,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [L-1:0]     out_index,
    output logic             out_found,
    output logic [TAG_W-1:0] out_tag
);
    logic             w_en;
    logic [W-1:0]     w_sel;
    logic [W-1:0]     w_pre;
    logic [MAX_W-1:0] w_rev;
    logic             w_last_bit;
    logic             w_found;

    logic             w_vld [0:L];
    logic [L:0]       w_k   [0:L];
    logic [L-1:0]     w_idx [0:L];
    logic             w_msb [0:L];
    logic [TAG_W-1:0] w_tag [0:L];

    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en && !flush;

    // Clear-mode and MSB-mode are folded into the data so every stage searches set bits from LSB.
    always_comb begin
        w_sel          = (in_mode_clear == MODE_CLEAR) ? ~in_data : in_data;
        w_rev          = '0;
        w_rev[W-1:0]   = w_sel;
        w_rev          = bit_reverse(w_rev, W);
        w_pre          = (in_mode_msb == DIR_MSB) ? w_rev[W-1:0] : w_sel;
    end

    assign w_vld[0] = in_valid && in_ready;
    assign w_k[0]   = in_k;
    assign w_idx[0] = '0;
    assign w_msb[0] = in_mode_msb;
    assign w_tag[0] = in_tag;

    for (genvar i = 0; i < L; i++) begin : g_st
        localparam int WI = W >> i;
        logic [WI-1:0]   w_win_i;
        logic [WI/2-1:0] w_win_o;

        if (i == 0) begin : g_first
            assign w_win_i = w_pre;
        end else begin : g_next
            assign w_win_i = g_st[i-1].w_win_o;
        end

        kth_descent_stage #(.WI(WI), .L(L), .TAG_W(TAG_W)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (w_en),
            .flush   (flush),
            .in_vld  (w_vld[i]),
            .in_win  (w_win_i),
            .in_k    (w_k[i]),
            .in_idx  (w_idx[i]),
            .in_msb  (w_msb[i]),
            .in_tag  (w_tag[i]),
            .out_vld (w_vld[i+1]),
            .out_win (w_win_o),
            .out_k   (w_k[i+1]),
            .out_idx (w_idx[i+1]),
            .out_msb (w_msb[i+1]),
            .out_tag (w_tag[i+1])
        );

        if (i == L - 1) begin : g_last
            assign w_last_bit = w_win_o[0];
        end
    end

    // Residual k of exactly 1 on a set bit covers both k=0 and k beyond the bit count.
    assign w_found   = (w_k[L] == (L+1)'(1)) && w_last_bit;
    assign out_valid = w_vld[L];
    assign out_found = w_found;
    assign out_tag   = w_tag[L];
    assign out_index = !w_found ? '0 :
                       (w_msb[L] == DIR_MSB) ? (L'(W-1) - w_idx[L]) : w_idx[L];
endmodule
